// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin one-hot arbiter.
package rr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_onehot_arbiter_pick.sv
// Rotating winner pick: first set request after last_idx, wrapping N-1 -> 0.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = 3
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] last_idx,
    output logic [IDXW-1:0] pick_idx,
    output logic            pick_valid
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] mask;
    int             start;
    int             hit;

    // Window [last_idx+1, last_idx+N] over the doubled vector covers one full rotation.
    always_comb begin
        dbl        = {req, req};
        mask       = '0;
        start      = int'(last_idx) + 1;
        hit        = 0;
        pick_valid = 1'b0;
        for (int j = 0; j < 2*N; j++)
            mask[j] = (j >= start) && (j < start + N);
        for (int j = 2*N-1; j >= 0; j--) begin
            if (dbl[j] && mask[j]) begin
                hit        = j;
                pick_valid = 1'b1;
            end
        end
        pick_idx = (hit >= N) ? IDXW'(hit - N) : IDXW'(hit);
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with max hold time and a one-cycle gap between grants.
module rr_onehot_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int N        = 8,
    parameter  int MAX_HOLD = 16,
    localparam int IDXW     = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid,
    output logic            preempt
);

    localparam int HW = clog2_min1(MAX_HOLD + 1);

    state_e          state;
    logic [IDXW-1:0] last_idx;
    logic [IDXW-1:0] pick_idx;
    logic            pick_valid;
    logic [HW-1:0]   hold_cnt;
    logic            cur_req;
    logic            timeout;

    rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
        .req        (req),
        .last_idx   (last_idx),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    assign cur_req = req[grant_idx];

    // Timeout only when the holder still requests; a simultaneous release wins.
    assign timeout = (MAX_HOLD != 0) && (state == GRANT) && cur_req &&
                     (hold_cnt == HW'(MAX_HOLD - 1));
    assign preempt = timeout;

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++)
            grant[i] = grant_valid && (grant_idx == IDXW'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            hold_cnt    <= '0;
            last_idx    <= IDXW'(N - 1);
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (en && pick_valid) begin
                        state       <= GRANT;
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    // Rotation advances on exit so the GAP cycle already picks with it.
                    if (!cur_req || timeout) begin
                        state       <= GAP;
                        grant_valid <= 1'b0;
                        last_idx    <= grant_idx;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter with hand-computed expectations.
module tb_rr_onehot_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       preempt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    rr_onehot_arbiter #(.N(8), .MAX_HOLD(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    // Structural invariants sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("onehot0", $onehot0(grant), 1);
            chk("grant_vs_idx", grant, grant_valid ? (8'd1 << grant_idx) : 8'd0);
            chk("preempt_impl_valid", !preempt || grant_valid, 1);
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 8'hFF;

        // 1: reset state, then first grant latency
        tick(); tick();
        chk("rst_grant", grant, 8'h00);
        chk("rst_valid", grant_valid, 0);
        chk("rst_idx", grant_idx, 0);
        chk("rst_preempt", preempt, 0);
        rst_n = 1'b1;
        req   = 8'h01;
        tick();
        chk("first_grant", grant, 8'h01);
        chk("first_idx", grant_idx, 0);
        req = 8'h00;
        tick(); tick();

        // 2: full rotation, 3-cycle grants with one gap cycle
        do_reset();
        req = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            logic [2:0] e;
            e = 3'(k % 8);
            chk("rot_c1_idx", grant_idx, e);
            chk("rot_c1_grant", grant, 8'd1 << e);
            tick();
            chk("rot_c2_valid", grant_valid, 1);
            tick();
            chk("rot_c3_idx", grant_idx, e);
            req = 8'hFF & ~(8'd1 << e);
            tick();
            chk("rot_gap_valid", grant_valid, 0);
            chk("rot_gap_idx", grant_idx, e);
            req = 8'hFF;
            if (k < 8) tick();
        end
        req = 8'h00;
        tick(); tick();

        // 3: wrap and sole-requester re-grant
        req = 8'h20;
        tick();
        chk("wrap_idx5", grant_idx, 5);
        req = 8'h00;
        tick();
        req = 8'h21;
        tick();
        chk("wrap_idx0", grant_idx, 0);
        req = 8'h80;
        tick();
        chk("wrap_gap", grant_valid, 0);
        tick();
        chk("idx7", grant_idx, 7);
        req = 8'h00;
        tick();
        req = 8'h80;
        tick();
        chk("idx7_regrant", grant, 8'h80);
        req = 8'h00;
        tick(); tick();

        // 4: timeout on sole requester, then with a competitor
        req = 8'h04;
        tick();
        for (int c = 1; c <= 16; c++) begin
            chk("to_grant", grant, 8'h04);
            chk("to_preempt", preempt, (c == 16) ? 1 : 0);
            if (c < 16) tick();
        end
        tick();
        chk("to_gap_valid", grant_valid, 0);
        chk("to_gap_preempt", preempt, 0);
        tick();
        chk("to_regrant", grant, 8'h04);
        req = 8'h0C;
        repeat (15) tick();
        chk("to2_preempt", preempt, 1);
        chk("to2_idx", grant_idx, 2);
        tick();
        chk("to2_gap", grant_valid, 0);
        tick();
        chk("to2_next_idx3", grant_idx, 3);
        req = 8'h00;
        tick(); tick();

        // 5: enable gating
        en  = 1'b0;
        req = 8'hFF;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("en0_nogrant", grant, 8'h00);
        end
        en = 1'b1;
        tick();
        chk("en1_idx4", grant_idx, 4);
        en = 1'b0;
        tick();
        chk("en_mid_valid", grant_valid, 1);
        chk("en_mid_grant", grant, 8'h10);
        req = 8'hEF;
        tick();
        chk("en_gap", grant_valid, 0);
        tick(); tick();
        chk("en_idle_grant", grant, 8'h00);
        chk("en_idle_idx", grant_idx, 4);

        // 6: async reset in the middle of a grant
        en  = 1'b1;
        req = 8'h10;
        tick();
        chk("ar_grant", grant, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_grant_clr", grant, 8'h00);
        chk("ar_valid_clr", grant_valid, 0);
        req   = 8'hFF;
        rst_n = 1'b1;
        tick();
        chk("ar_first_idx0", grant_idx, 0);
        chk("ar_first_grant", grant, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
